// File: rtl/vfu_result_wb_arbiter.sv
// vfu_result_wb_arbiter
//   Buffers ALU and MFPU result words in one small FIFO per source and
//   arbitrates the FIFO heads onto a single VRF write port. Round-robin
//   priority between the two sources, with a lock that freezes the selection
//   and payload while the VRF port is stalling.
//
// Ports
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   alu_result_*_i / _gnt_o       ALU result handshake and payload
//   mfpu_result_*_i / _gnt_o      MFPU result handshake and payload
//   vrf_req_o, vrf_*_o            VRF write request and selected payload
//   vrf_src_o                     0 = ALU entry, 1 = MFPU entry
//   vrf_gnt_i                     VRF accepted the request this cycle
//   alu_cnt_o, mfpu_cnt_o         FIFO occupancy
module vfu_result_wb_arbiter #(
  parameter  int unsigned NrSimd    = 2,
  parameter  int unsigned Depth     = 2,
  parameter  int unsigned AddrWidth = 10,
  parameter  int unsigned IdWidth   = 3,
  localparam int unsigned DataWidth = 64 * NrSimd,
  localparam int unsigned BeWidth   = DataWidth / 8,
  localparam int unsigned CntWidth  = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 alu_result_req_i,
  input  logic [IdWidth-1:0]   alu_result_id_i,
  input  logic [AddrWidth-1:0] alu_result_addr_i,
  input  logic [DataWidth-1:0] alu_result_wdata_i,
  input  logic [BeWidth-1:0]   alu_result_be_i,
  output logic                 alu_result_gnt_o,
  input  logic                 mfpu_result_req_i,
  input  logic [IdWidth-1:0]   mfpu_result_id_i,
  input  logic [AddrWidth-1:0] mfpu_result_addr_i,
  input  logic [DataWidth-1:0] mfpu_result_wdata_i,
  input  logic [BeWidth-1:0]   mfpu_result_be_i,
  output logic                 mfpu_result_gnt_o,
  output logic                 vrf_req_o,
  output logic [IdWidth-1:0]   vrf_id_o,
  output logic [AddrWidth-1:0] vrf_addr_o,
  output logic [DataWidth-1:0] vrf_wdata_o,
  output logic [BeWidth-1:0]   vrf_be_o,
  output logic                 vrf_src_o,
  input  logic                 vrf_gnt_i,
  output logic [CntWidth-1:0]  alu_cnt_o,
  output logic [CntWidth-1:0]  mfpu_cnt_o
);

  localparam int unsigned PtrWidth = $clog2(Depth);

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] wdata;
    logic [BeWidth-1:0]   be;
  } entry_t;

  typedef enum logic {
    SRC_ALU  = 1'b0,
    SRC_MFPU = 1'b1
  } src_e;

  logic [1:0]          in_req;
  entry_t              in_entry [2];
  logic [1:0]          push;
  logic [1:0]          pop;
  logic [1:0]          nonempty;
  entry_t              head     [2];
  logic [CntWidth-1:0] cnt      [2];

  src_e   prio;
  src_e   locked_sel;
  logic   lock;
  src_e   sel;
  entry_t sel_head;

  assign in_req      = {mfpu_result_req_i, alu_result_req_i};
  assign in_entry[0] = {alu_result_id_i, alu_result_addr_i, alu_result_wdata_i, alu_result_be_i};
  assign in_entry[1] = {mfpu_result_id_i, mfpu_result_addr_i, mfpu_result_wdata_i, mfpu_result_be_i};

  for (genvar s = 0; s < 2; s++) begin : g_fifo
    entry_t              mem [Depth];
    logic [PtrWidth-1:0] wptr;
    logic [PtrWidth-1:0] rptr;
    logic [CntWidth-1:0] count;

    // Grant only on free space seen at the start of the cycle: a pop in the
    // same cycle does not open a slot for the push (no bypass). Held low in
    // reset so every output reads 0 while rst_ni is asserted.
    assign push[s]     = rst_ni && in_req[s] && (count < CntWidth'(Depth));
    assign nonempty[s] = (count != '0);
    assign head[s]     = mem[rptr];
    assign cnt[s]      = count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push[s]) wptr <= wptr + 1'b1;
        if (pop[s])  rptr <= rptr + 1'b1;
        unique case ({push[s], pop[s]})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end

    always_ff @(posedge clk_i) begin
      if (push[s]) mem[wptr] <= in_entry[s];
    end

    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
      push[s] |-> (count != CntWidth'(Depth)));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
      pop[s] |-> (count != '0));
  end

  assign vrf_req_o = |nonempty;

  always_comb begin
    sel = SRC_ALU;
    if (lock)                  sel = locked_sel;
    else if (nonempty == 2'b11) sel = prio;
    else if (nonempty[1])      sel = SRC_MFPU;

    pop = '0;
    if (vrf_req_o && vrf_gnt_i) begin
      if (sel == SRC_MFPU) pop[1] = 1'b1;
      else                 pop[0] = 1'b1;
    end

    sel_head = (sel == SRC_MFPU) ? head[1] : head[0];
  end

  // The lock remembers the source presented during a stall; that FIFO cannot
  // pop until the grant, so its head (and therefore the payload) is frozen.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prio       <= SRC_ALU;
      locked_sel <= SRC_ALU;
      lock       <= 1'b0;
    end else if (vrf_req_o) begin
      if (vrf_gnt_i) begin
        lock <= 1'b0;
        prio <= (sel == SRC_ALU) ? SRC_MFPU : SRC_ALU;
      end else begin
        lock       <= 1'b1;
        locked_sel <= sel;
      end
    end
  end

  assign alu_result_gnt_o  = push[0];
  assign mfpu_result_gnt_o = push[1];
  assign alu_cnt_o         = cnt[0];
  assign mfpu_cnt_o        = cnt[1];

  assign vrf_id_o    = vrf_req_o ? sel_head.id    : '0;
  assign vrf_addr_o  = vrf_req_o ? sel_head.addr  : '0;
  assign vrf_wdata_o = vrf_req_o ? sel_head.wdata : '0;
  assign vrf_be_o    = vrf_req_o ? sel_head.be    : '0;
  assign vrf_src_o   = vrf_req_o && (sel == SRC_MFPU);

  a_payload_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (vrf_req_o && !vrf_gnt_i) |=> (vrf_req_o && $stable(vrf_src_o) && $stable(vrf_id_o)
      && $stable(vrf_addr_o) && $stable(vrf_wdata_o) && $stable(vrf_be_o)));

endmodule

// File: doc/vfu_result_wb_arbiter.md
Name: vfu_result_wb_arbiter

Overview:
- Sits directly downstream of the lane's vector functional-unit stage, between the ALU/MFPU result ports and one write port of the lane's vector register file (VRF).
- Each source has its own result FIFO, so a stalled VRF port does not immediately back-pressure the functional units.
- Result words are full SIMD width (NrSimd x 64 bits) with per-byte strobes.
- A round-robin arbiter with a lock picks one FIFO head per cycle for the VRF write request.

Parameters:
- NrSimd, 2, number of 64-bit sub-words per result word.
- Depth, 2, entries per source FIFO; power of two, >= 2.
- AddrWidth, 10, width of the VRF address field.
- IdWidth, 3, width of the vector instruction id field.
- DataWidth, 64*NrSimd, derived; do not override.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- alu_result_req_i  in  1  ALU result valid.
- alu_result_id_i  in  IdWidth  instruction id.
- alu_result_addr_i  in  AddrWidth  VRF address.
- alu_result_wdata_i  in  DataWidth  write data.
- alu_result_be_i  in  DataWidth/8  byte enables.
- alu_result_gnt_o  out  1  ALU result accepted this cycle.
- mfpu_result_req_i / _id_i / _addr_i / _wdata_i / _be_i  in  (as ALU)  MFPU result.
- mfpu_result_gnt_o  out  1  MFPU result accepted this cycle.
- vrf_req_o  out  1  VRF write request.
- vrf_id_o  out  IdWidth  id of the selected entry.
- vrf_addr_o  out  AddrWidth  address of the selected entry.
- vrf_wdata_o  out  DataWidth  data of the selected entry.
- vrf_be_o  out  DataWidth/8  byte enables of the selected entry.
- vrf_src_o  out  1  0 = ALU entry, 1 = MFPU entry.
- vrf_gnt_i  in  1  VRF accepted the request this cycle.
- alu_cnt_o / mfpu_cnt_o  out  $clog2(Depth+1)  FIFO occupancy.

Behaviour:
- Reset (asynchronous, rst_ni=0):
  - Both FIFOs empty; pointers and counts 0.
  - Round-robin priority set to ALU; lock cleared.
  - All outputs 0: vrf_req_o=0, both gnt_o=0, cnt_o=0, data/addr/id/be/src=0.
  - Reset mid-operation discards all buffered entries without any VRF write.
- Enqueue:
  - src_gnt_o = src_req_i & (cnt < Depth). This path is combinational, zero cycle.
  - When full, gnt stays 0, even if a pop happens in the same cycle. No bypass.
  - Source holds req and payload stable until gnt. A push is captured at the clock edge where req & gnt.
- Dequeue / arbitration:
  - vrf_req_o = 1 iff at least one FIFO is non-empty.
  - The payload is the selected FIFO head, driven combinationally from storage.
  - Selection when unlocked:
    - Only one FIFO non-empty: select it.
    - Both non-empty: select the prio source.
  - While vrf_req_o=1 & vrf_gnt_i=0, set lock. Selection and payload must stay constant until gnt, even if the other FIFO becomes non-empty.
  - On vrf_req_o & vrf_gnt_i:
    - Pop the selected head.
    - Clear the lock.
    - Set prio to the other source.
- Simultaneous events:
  - Push and pop on the same FIFO in one cycle: count unchanged, both operations honoured.
  - Pushes to both FIFOs in one cycle are allowed.
  - vrf_gnt_i while vrf_req_o=0 is ignored.
- Ordering: entries from one source leave in FIFO order. No ordering guarantee between sources.
- Pointers wrap modulo Depth. Count is tracked separately, to distinguish full from empty.
- Latency: an entry pushed into an empty FIFO at edge N is presented on vrf_req_o in cycle N+1.
- Byte enables and data pass through unmodified. The block never drops or merges entries.
- Assertions:
  - No push when full.
  - No pop when empty.
  - Payload stable while vrf_req_o & !vrf_gnt_i.

Test Plan:
- Reset then idle: all outputs 0. Single ALU push (addr=0x010, id=2, wdata=0xA5.., be=0xFFFF) -> next cycle vrf_req_o=1, src=0, payload matches; vrf_gnt_i=1 pops it, alu_cnt_o returns to 0.
- Depth=2, vrf_gnt_i held 0, ALU req held 3 cycles -> alu_gnt_o=1,1,0; alu_cnt_o=2. The third entry is accepted only after the first VRF gnt frees a slot.
- Both FIFOs loaded with 2 entries each, vrf_gnt_i=1 every cycle -> vrf_src_o sequence 0,1,0,1. Each source's addresses exit in push order.
- Lock: MFPU entry presented with gnt=0 for 3 cycles while an ALU entry arrives and prio=ALU -> src stays 1 and the payload is unchanged until gnt; the ALU entry follows next.
- Same-cycle push and pop on a FIFO with cnt=1 -> cnt stays 1, and the popped/pushed data order is correct.
- Assert rst_ni with 3 entries buffered and vrf_req_o=1 -> outputs drop to 0 immediately; after release, no stale write appears.
